// File: rtl/chip8_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// chip8_pkg - keypad geometry and matrix position to CHIP-8 key index map
// Revision: 1.0
//------------------------------------------------------------------------------
package chip8_pkg;

  localparam int NUM_KEYS   = 16;
  localparam int KEYPAD_DIM = 4;

  // Indexed by row*KEYPAD_DIM + col.
  localparam logic [3:0] KEY_MAP [NUM_KEYS] = '{
    4'h1, 4'h2, 4'h3, 4'hC,
    4'h4, 4'h5, 4'h6, 4'hD,
    4'h7, 4'h8, 4'h9, 4'hE,
    4'hA, 4'h0, 4'hB, 4'hF
  };

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
//------------------------------------------------------------------------------
// key_debounce - per-key scan-count debouncer with a rising-edge indication
// Revision: 1.0
//------------------------------------------------------------------------------
module key_debounce #(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic scan_done,
  input  logic raw,
  output logic state,
  output logic rose
);

  localparam int CNT_W = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

  logic             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // rose is combinational so the top can register key_down on the same edge
  // that state_q takes its new value.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rose    = 1'b0;
    if (scan_done) begin
      if (raw == state_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        state_d = raw;
        cnt_d   = '0;
        rose    = raw;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state = state_q;

endmodule
`default_nettype wire

// File: rtl/chip8_keypad.sv
`default_nettype none
//------------------------------------------------------------------------------
// chip8_keypad - 4x4 active-low matrix scanner with per-key debounce
// Revision: 1.0
//------------------------------------------------------------------------------
module chip8_keypad
  import chip8_pkg::*;
#(
  parameter int SCAN_DIV       = 4096,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  output logic [15:0] keys,
  output logic        key_down,
  output logic [3:0]  key_code
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [3:0]       sync1_q, sync1_d;
  logic [3:0]       row_s_q, row_s_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_q, col_d;
  logic [3:0][3:0]  raw_q, raw_d;        // [col][row], 1 = pressed
  logic             scan_done_q, scan_done_d;
  logic             key_down_q, key_down_d;
  logic [3:0]       key_code_q, key_code_d;

  logic             scan_tick;
  logic [15:0]      raw_keys;
  logic [15:0]      rose;
  logic [3:0]       first_rose;

  always_comb begin
    sync1_d     = row_in;
    row_s_d     = sync1_q;
    scan_tick   = (div_q == DIV_LAST);
    div_d       = scan_tick ? '0 : div_q + DIV_W'(1);
    col_d       = scan_tick ? col_q + 2'd1 : col_q;
    raw_d       = raw_q;
    if (scan_tick) begin
      raw_d[col_q] = ~row_s_q;
    end
    scan_done_d = scan_tick && (col_q == 2'd3);
  end

  always_comb begin
    raw_keys = '0;
    for (int r = 0; r < KEYPAD_DIM; r++) begin
      for (int c = 0; c < KEYPAD_DIM; c++) begin
        raw_keys[KEY_MAP[r*KEYPAD_DIM + c]] = raw_q[c][r];
      end
    end
  end

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
      .clk      (clk),
      .reset    (reset),
      .scan_done(scan_done_q),
      .raw      (raw_keys[k]),
      .state    (keys[k]),
      .rose     (rose[k])
    );
  end

  // Descending walk so the lowest rising index is the one that sticks.
  always_comb begin
    first_rose = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (rose[k]) begin
        first_rose = 4'(k);
      end
    end
    key_down_d = |rose;
    key_code_d = (|rose) ? first_rose : key_code_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q     <= 4'hF;
      row_s_q     <= 4'hF;
      div_q       <= '0;
      col_q       <= 2'd0;
      raw_q       <= '0;
      scan_done_q <= 1'b0;
      key_down_q  <= 1'b0;
      key_code_q  <= 4'h0;
    end else begin
      sync1_q     <= sync1_d;
      row_s_q     <= row_s_d;
      div_q       <= div_d;
      col_q       <= col_d;
      raw_q       <= raw_d;
      scan_done_q <= scan_done_d;
      key_down_q  <= key_down_d;
      key_code_q  <= key_code_d;
    end
  end

  assign col_out  = ~(4'b0001 << col_q);
  assign key_down = key_down_q;
  assign key_code = key_code_q;

endmodule
`default_nettype wire

// File: tb/tb_chip8_keypad.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_chip8_keypad - keypad matrix model plus scan-level reference model
// Revision: 1.0
//------------------------------------------------------------------------------
module tb_chip8_keypad;

  localparam int SCAN_DIV    = 4;
  localparam int DB          = 3;
  localparam int SCAN_CYCLES = 4 * SCAN_DIV;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [15:0] keys;
  logic        key_down;
  logic [3:0]  key_code;

  logic [15:0] mask = 16'h0000;   // keys physically held
  int          compared   = 0;
  int          mismatched = 0;
  int          edges      = 0;    // clock edges since reset release

  // Reference: debounced keys, consecutive-disagreement run per key, last code.
  logic [15:0] m_keys;
  int          m_run [16];
  logic [3:0]  m_code;

  chip8_keypad #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DB)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .row_in  (row_in),
    .col_out (col_out),
    .keys    (keys),
    .key_down(key_down),
    .key_code(key_code)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] key_at(input int r, input int c);
    case (r * 4 + c)
      0: return 4'h1;   1: return 4'h2;   2: return 4'h3;   3: return 4'hC;
      4: return 4'h4;   5: return 4'h5;   6: return 4'h6;   7: return 4'hD;
      8: return 4'h7;   9: return 4'h8;  10: return 4'h9;  11: return 4'hE;
     12: return 4'hA;  13: return 4'h0;  14: return 4'hB;  default: return 4'hF;
    endcase
  endfunction

  // Passive matrix: a held key pulls its row low while its column is driven.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (col_out[c] == 1'b0 && mask[key_at(r, c)]) row_in[r] = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_keys = 16'h0;
    m_code = 4'h0;
    for (int k = 0; k < 16; k++) m_run[k] = 0;
  endtask

  // One completed scan: a key flips after DB consecutive disagreeing scans.
  task automatic model_scan(input logic [15:0] raw, output logic down);
    logic [15:0] risen;
    risen = 16'h0;
    for (int k = 0; k < 16; k++) begin
      if (raw[k] != m_keys[k]) begin
        m_run[k] = m_run[k] + 1;
        if (m_run[k] == DB) begin
          if (raw[k]) risen[k] = 1'b1;
          m_keys[k] = raw[k];
          m_run[k]  = 0;
        end
      end else begin
        m_run[k] = 0;
      end
    end
    down = |risen;
    for (int k = 15; k >= 0; k--) begin
      if (risen[k]) m_code = 4'(k);
    end
  endtask

  task automatic step();
    int col;
    @(posedge clk);
    #1;
    edges++;
    col = (edges / SCAN_DIV) % 4;
    check("col_out", {12'h0, col_out}, {12'h0, 4'(~(4'b0001 << col))});
  endtask

  // Starts just after a keys-update edge; a full scan ends on the next one.
  task automatic run_scan(input logic [15:0] m, input int n_edges);
    logic exp_down;
    mask = m;
    for (int i = 1; i <= n_edges; i++) begin
      step();
      exp_down = 1'b0;
      if (i == SCAN_CYCLES) model_scan(m, exp_down);
      check("key_down", {15'h0, key_down}, {15'h0, exp_down});
      check("key_code", {12'h0, key_code}, {12'h0, m_code});
      check("keys", keys, m_keys);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("rst_col_out", {12'h0, col_out}, 16'h000E);
    check("rst_keys", keys, 16'h0000);
    check("rst_key_down", {15'h0, key_down}, 16'h0000);
    check("rst_key_code", {12'h0, key_code}, 16'h0000);
    model_clear();
    reset = 1'b1;
    @(posedge clk);
    #1;
    edges = 1;
    check("rel_col_out", {12'h0, col_out}, 16'h000E);
  endtask

  initial begin
    logic [15:0] m;

    do_reset();
    run_scan(16'h0000, SCAN_CYCLES);

    // Key 5 held: debounced at the 3rd scan, single strobe.
    repeat (3) run_scan(16'h0020, SCAN_CYCLES);
    check("k5_keys", keys, 16'h0020);
    check("k5_code", {12'h0, key_code}, 16'h0005);
    run_scan(16'h0020, SCAN_CYCLES);

    // Release: clears after 3 scans, no strobe.
    repeat (3) run_scan(16'h0000, SCAN_CYCLES);
    check("k5_release", keys, 16'h0000);

    // Bounce never reaches 3 consecutive scans.
    repeat (4) begin
      repeat (2) run_scan(16'h0020, SCAN_CYCLES);
      run_scan(16'h0000, SCAN_CYCLES);
    end
    check("bounce_keys", keys, 16'h0000);

    // A and 0 together: lowest index wins; then F added.
    repeat (3) run_scan(16'h0401, SCAN_CYCLES);
    check("a0_keys", keys, 16'h0401);
    check("a0_code", {12'h0, key_code}, 16'h0000);
    repeat (3) run_scan(16'h8401, SCAN_CYCLES);
    check("f_keys", keys, 16'h8401);
    check("f_code", {12'h0, key_code}, 16'h000F);
    repeat (3) run_scan(16'h0000, SCAN_CYCLES);
    check("all_release", keys, 16'h0000);

    // Reset in the 2nd scan of a key 5 press discards progress.
    run_scan(16'h0020, SCAN_CYCLES);
    run_scan(16'h0020, SCAN_CYCLES / 2);
    do_reset();
    check("rst_mid_keys", keys, 16'h0000);
    repeat (2) run_scan(16'h0020, SCAN_CYCLES);
    check("rst_2scans", keys, 16'h0000);
    run_scan(16'h0020, SCAN_CYCLES);
    check("rst_3scans", keys, 16'h0020);

    // Random sparse key sets, each held for a random number of scans.
    m = 16'h0020;
    repeat (60) begin
      if ($urandom_range(0, 3) == 0) m = 16'($urandom) & 16'($urandom) & 16'($urandom);
      run_scan(m, SCAN_CYCLES);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
